ps2_mouse_rx: RTL and testbench
===============================

Name: ps2_mouse_rx

Overview:
- Upstream stage of the cursor mover.
- Receives the PS/2 mouse serial stream and assembles 3-byte movement packets.
- Converts each packet into scaled, saturated 5-bit per-axis deltas in screen orientation.
- Emits the cursor strobe pair (clk_cursor / prev_clk_cursor) that the mover edge-detects to apply one step per packet.

Parameters:
- SHIFT, 2: arithmetic right-shift applied to raw 9-bit counts before saturation (speed divider).
- TIMEOUT_CYCLES, 100000: clk cycles of ps2_clk inactivity mid-frame before the frame is abandoned.
- SYNC_STAGES, 2: synchroniser depth on ps2_clk / ps2_data.

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock (asynchronous)
- ps2_data  in  1  raw PS/2 data (asynchronous)
- delta_x  out  5  two's-complement X step, +right
- delta_y  out  5  two's-complement Y step, +down (screen)
- clk_cursor  out  1  one-cycle high pulse per valid packet
- prev_clk_cursor  out  1  clk_cursor delayed one clk
- btn_left  out  1  left button, from last valid packet
- btn_right  out  1  right button, from last valid packet
- pkt_err  out  1  one-cycle pulse on framing, parity or timeout error

Behaviour:
- One clock (clk); reset asynchronous, active-low (clr_n); all state in the clk domain.
- Reset: delta_x=0, delta_y=0, clk_cursor=0, prev_clk_cursor=0, btn_left=0, btn_right=0, pkt_err=0. Bit FSM returns to IDLE, byte index to 0. Holds for a reset asserted mid-frame.
- ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is detected as prev_sync=1, sync=0. ps2_data is sampled on that edge.
- Bit FSM states:
  - IDLE: on falling edge with data=0 (start bit), go to DATA with bitcnt=0. Data=1 stays in IDLE.
  - DATA: shift in 8 bits, LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the bit; odd parity over the 8 data bits plus the parity bit is required. Go to STOP.
  - STOP: bit must be 1. Byte is valid if parity is OK and stop=1; otherwise pkt_err pulses and byte index resets to 0. Go to IDLE.
- Timeout: in any state other than IDLE, a counter counts clk cycles since the last falling edge. At TIMEOUT_CYCLES: go to IDLE, byte index=0, pkt_err pulses. The counter clears on every edge.
- Packet assembly:
  - Byte 0: accepted only if bit3=1. Otherwise discard silently (no err) and stay at index 0 (resync).
  - Byte 0 fields: bit0=L, bit1=R, bit4=X sign, bit5=Y sign, bit6=X ovf, bit7=Y ovf.
  - Byte 1 = X low 8 bits. Byte 2 = Y low 8 bits.
- Arithmetic, computed on the byte-2 completion, in 11-bit signed:
  - x = {xs, byte1}; y = -{ys, byte2}, negated for screen-down orientation. The -(-256) = +256 case must not wrap.
  - Overflow flag set: force the axis to +1023 or -1024 according to the post-orientation sign.
  - Apply arithmetic >>> SHIFT, then saturate to [-16, +15].
- Output timing:
  - The clk after the STOP sample of byte 2: delta_x, delta_y, btn_left and btn_right update, and clk_cursor=1 for exactly that cycle.
  - prev_clk_cursor equals clk_cursor one cycle later.
  - Deltas and buttons hold until the next valid packet.
- pkt_err and clk_cursor never assert in the same cycle.

Test Plan:
- Frames 0x08,0x05,0x03 with SHIFT=0, valid parity → one clk_cursor pulse; delta_x=0x05, delta_y=0x1D (-3); prev_clk_cursor pulses one cycle later; pkt_err never asserts.
- Frames 0x19,0xF0,0x00 with SHIFT=2 → delta_x=0x1C (-4), delta_y=0x00, btn_left=1.
- Frames 0x08,0x64,0x00 with SHIFT=0 → delta_x=0x0F (saturated +15). Frames 0x48,0x00,0x00 (X ovf) → delta_x=0x0F.
- Byte 1 sent with bad parity → pkt_err one-cycle pulse, no clk_cursor. The next clean packet 0x08,0x01,0x01 → delta_x=0x01, delta_y=0x1F.
- Stray byte 0x00, then packet 0x08,0x02,0x00 → byte discarded, no err; single clk_cursor; delta_x=0x02.
- ps2_clk held high for TIMEOUT_CYCLES after 4 bits → pkt_err pulse. clr_n low mid-frame → all outputs 0; the next full packet decodes correctly.

Source files
------------

// File: rtl/ps2_mouse_rx_if.sv
// ps2_mouse_rx_if
//   Bundles the PS/2 line inputs and the decoded cursor outputs of
//   ps2_mouse_rx.
//   master : the receiver (samples the PS/2 lines, drives the decoded outputs)
//   slave  : the environment (drives the PS/2 lines, consumes the outputs)
//   Signals:
//     ps2_clk, ps2_data  raw asynchronous PS/2 lines
//     delta_x, delta_y   5-bit two's-complement steps (+right / +down)
//     clk_cursor         one-cycle strobe per valid packet
//     prev_clk_cursor    clk_cursor delayed by one clk
//     btn_left/right     button state from the last valid packet
//     pkt_err            one-cycle strobe on framing/parity/timeout error
`timescale 1ns/1ps
interface ps2_mouse_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] delta_x;
    logic [4:0] delta_y;
    logic       clk_cursor;
    logic       prev_clk_cursor;
    logic       btn_left;
    logic       btn_right;
    logic       pkt_err;

    modport master (
        input  ps2_clk, ps2_data,
        output delta_x, delta_y, clk_cursor, prev_clk_cursor,
               btn_left, btn_right, pkt_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  delta_x, delta_y, clk_cursor, prev_clk_cursor,
               btn_left, btn_right, pkt_err
    );
endinterface

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx
//   Receives the PS/2 mouse stream, assembles 3-byte movement packets and
//   turns each into scaled, saturated 5-bit per-axis deltas in screen
//   orientation, plus the clk_cursor / prev_clk_cursor strobe pair used by
//   the downstream cursor mover.
//   Ports:
//     clk    system clock
//     clr_n  asynchronous active-low reset
//     bus    ps2_mouse_rx_if.master (PS/2 lines in, decoded outputs out)
//   Parameters:
//     SHIFT           arithmetic right shift on raw counts (speed divider)
//     TIMEOUT_CYCLES  clk cycles without a ps2_clk fall before a frame is dropped
//     SYNC_STAGES     synchroniser depth on ps2_clk / ps2_data
`timescale 1ns/1ps
module ps2_mouse_rx #(
    parameter int SHIFT          = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input logic           clk,
    input logic           clr_n,
    ps2_mouse_rx_if.master bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Raw 9-bit count -> 11-bit signed in screen orientation. Negating first
    // keeps -(-256) = +256 representable; overflow forces full scale by the
    // post-orientation sign.
    function automatic logic signed [10:0] orient(input logic       sign,
                                                  input logic [7:0] low,
                                                  input logic       ovf,
                                                  input logic       flip);
        logic signed [10:0] v;
        v = signed'({{3{sign}}, low});
        if (flip)
            v = -v;
        if (ovf)
            v = v[10] ? 11'sb100_0000_0000 : 11'sb011_1111_1111;
        return v;
    endfunction

    function automatic logic signed [4:0] scale_sat(input logic signed [10:0] v);
        logic signed [10:0] s;
        s = v >>> SHIFT;
        if (s > 11'sd15)
            return 5'sd15;
        else if (s < -11'sd16)
            return -5'sd16;
        else
            return signed'(s[4:0]);
    endfunction

    // ---------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   bit_in;
    logic                   fall;

    // Lines idle high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync[0]  <= bus.ps2_clk;
            data_sync[0] <= bus.ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            clk_prev <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // ---------------------------------------------------------------
    // Bit FSM: state register / next state / strobes
    // ---------------------------------------------------------------
    state_t          state;
    state_t          state_nxt;
    logic [2:0]      bitcnt;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      shift_reg;
    logic            parity_bit;
    logic [1:0]      byte_idx;
    logic            timeout;
    logic            parity_ok;
    logic            byte_ok;
    logic            frame_err;
    logic            pkt_done;

    assign timeout   = (state != S_IDLE) && !fall &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign parity_ok = ^{shift_reg, parity_bit};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!bit_in) state_nxt = S_DATA;
                S_DATA:   if (bitcnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        pkt_done  = 1'b0;
        if (state == S_STOP && fall) begin
            byte_ok   = bit_in & parity_ok;
            frame_err = ~(bit_in & parity_ok);
        end
        pkt_done = byte_ok && (byte_idx == 2'd2);
    end

    // Bit counter, inactivity counter and byte index are control state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bitcnt   <= '0;
            to_cnt   <= '0;
            byte_idx <= '0;
        end else begin
            if (state == S_IDLE || fall)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (state == S_IDLE)
                bitcnt <= '0;
            else if (state == S_DATA && fall)
                bitcnt <= bitcnt + 1'b1;

            if (timeout || frame_err) begin
                byte_idx <= '0;
            end else if (byte_ok) begin
                case (byte_idx)
                    // A header without bit3 set is a misaligned byte: stay
                    // at index 0 until a plausible header appears.
                    2'd0:    byte_idx <= shift_reg[3] ? 2'd1 : 2'd0;
                    2'd1:    byte_idx <= 2'd2;
                    default: byte_idx <= 2'd0;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Byte capture (data path, not reset)
    // ---------------------------------------------------------------
    logic       hdr_l, hdr_r, hdr_xs, hdr_ys, hdr_xo, hdr_yo;
    logic [7:0] byte1;

    always_ff @(posedge clk) begin
        if (state == S_DATA && fall)
            shift_reg <= {bit_in, shift_reg[7:1]};
        if (state == S_PARITY && fall)
            parity_bit <= bit_in;
        if (byte_ok && byte_idx == 2'd0) begin
            hdr_l  <= shift_reg[0];
            hdr_r  <= shift_reg[1];
            hdr_xs <= shift_reg[4];
            hdr_ys <= shift_reg[5];
            hdr_xo <= shift_reg[6];
            hdr_yo <= shift_reg[7];
        end
        if (byte_ok && byte_idx == 2'd1)
            byte1 <= shift_reg;
    end

    // ---------------------------------------------------------------
    // Stage p0: delta arithmetic on byte-2 completion (shift_reg = byte 2)
    // ---------------------------------------------------------------
    logic signed [4:0] dx_p0;
    logic signed [4:0] dy_p0;
    logic              vld_p0;

    assign dx_p0  = scale_sat(orient(hdr_xs, byte1,     hdr_xo, 1'b0));
    assign dy_p0  = scale_sat(orient(hdr_ys, shift_reg, hdr_yo, 1'b1));
    assign vld_p0 = pkt_done;

    // ---------------------------------------------------------------
    // Stage p1: registered outputs and strobes
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus.delta_x         <= '0;
            bus.delta_y         <= '0;
            bus.btn_left        <= 1'b0;
            bus.btn_right       <= 1'b0;
            bus.clk_cursor      <= 1'b0;
            bus.prev_clk_cursor <= 1'b0;
            bus.pkt_err         <= 1'b0;
        end else begin
            if (vld_p0) begin
                bus.delta_x   <= dx_p0;
                bus.delta_y   <= dy_p0;
                bus.btn_left  <= hdr_l;
                bus.btn_right <= hdr_r;
            end
            bus.clk_cursor      <= vld_p0;
            bus.prev_clk_cursor <= bus.clk_cursor;
            // Errors come from a failed STOP sample or a timeout; neither
            // can coincide with a good byte-2 STOP sample.
            bus.pkt_err         <= frame_err | timeout;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
`timescale 1ns/1ps
module tb_ps2_mouse_rx;

    localparam int HALF = 20;
    localparam int TO   = 300;

    logic clk = 1'b0;
    logic clr_n;
    logic ps2c;
    logic ps2d;

    always #5 clk = ~clk;

    ps2_mouse_rx_if if0 ();
    ps2_mouse_rx_if if2 ();

    assign if0.ps2_clk  = ps2c;
    assign if0.ps2_data = ps2d;
    assign if2.ps2_clk  = ps2c;
    assign if2.ps2_data = ps2d;

    ps2_mouse_rx #(.SHIFT(0), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .clr_n(clr_n), .bus(if0));
    ps2_mouse_rx #(.SHIFT(2), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .clr_n(clr_n), .bus(if2));

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse monitors (sampled on the falling clk edge)
    int   cur0 = 0, err0 = 0, cur2 = 0, err2 = 0;
    int   prev_bad = 0, both = 0;
    logic last_cur0 = 1'b0;

    always @(negedge clk) begin
        if (if0.clk_cursor === 1'b1) cur0 <= cur0 + 1;
        if (if0.pkt_err === 1'b1)    err0 <= err0 + 1;
        if (if2.clk_cursor === 1'b1) cur2 <= cur2 + 1;
        if (if2.pkt_err === 1'b1)    err2 <= err2 + 1;
        if (if0.prev_clk_cursor !== last_cur0) prev_bad <= prev_bad + 1;
        if (if0.clk_cursor === 1'b1 && if0.pkt_err === 1'b1) both <= both + 1;
        last_cur0 <= if0.clk_cursor;
    end

    int c0s, e0s, c2s, e2s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        wait_clks(HALF);
        ps2c = 1'b0;
        wait_clks(HALF);
        ps2c = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        wait_clks(HALF);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
    endtask

    task automatic snap();
        @(negedge clk); #1;
        c0s = cur0; e0s = err0; c2s = cur2; e2s = err2;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic expect_pkt(input string tag,
                              input logic [4:0] dx0, input logic [4:0] dy0,
                              input logic [4:0] dx2, input logic [4:0] dy2,
                              input logic bl, input logic br);
        settle();
        check({tag, "_cur0"}, cur0 - c0s, 1);
        check({tag, "_err0"}, err0 - e0s, 0);
        check({tag, "_cur2"}, cur2 - c2s, 1);
        check({tag, "_dx0"}, {27'd0, if0.delta_x}, {27'd0, dx0});
        check({tag, "_dy0"}, {27'd0, if0.delta_y}, {27'd0, dy0});
        check({tag, "_dx2"}, {27'd0, if2.delta_x}, {27'd0, dx2});
        check({tag, "_dy2"}, {27'd0, if2.delta_y}, {27'd0, dy2});
        check({tag, "_bl"}, {31'd0, if0.btn_left}, {31'd0, bl});
        check({tag, "_br"}, {31'd0, if0.btn_right}, {31'd0, br});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_n = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        #2 clr_n = 1'b0;
        wait_clks(5);
        clr_n = 1'b1;
        wait_clks(5);
        settle();

        // Reset state
        check("rst_dx", {27'd0, if0.delta_x}, 32'd0);
        check("rst_dy", {27'd0, if0.delta_y}, 32'd0);
        check("rst_cur", {31'd0, if0.clk_cursor}, 32'd0);
        check("rst_prev", {31'd0, if0.prev_clk_cursor}, 32'd0);
        check("rst_bl", {31'd0, if0.btn_left}, 32'd0);
        check("rst_br", {31'd0, if0.btn_right}, 32'd0);
        check("rst_err", {31'd0, if0.pkt_err}, 32'd0);

        // x=+5, y=-3 ; SHIFT2: 1, -1
        snap();
        send_pkt(8'h08, 8'h05, 8'h03);
        expect_pkt("p1", 5'h05, 5'h1D, 5'h01, 5'h1F, 1'b0, 1'b0);

        // x=-16, y=0, left button ; SHIFT2: x=-4
        snap();
        send_pkt(8'h19, 8'hF0, 8'h00);
        expect_pkt("p2", 5'h10, 5'h00, 5'h1C, 5'h00, 1'b1, 1'b0);

        // x=+100 saturates on both instances
        snap();
        send_pkt(8'h08, 8'h64, 8'h00);
        expect_pkt("p3", 5'h0F, 5'h00, 5'h0F, 5'h00, 1'b0, 1'b0);

        // X overflow flag forces +full scale
        snap();
        send_pkt(8'h48, 8'h00, 8'h00);
        expect_pkt("p4", 5'h0F, 5'h00, 5'h0F, 5'h00, 1'b0, 1'b0);

        // Bad parity on byte 1
        snap();
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b1);
        settle();
        check("par_err0", err0 - e0s, 1);
        check("par_cur0", cur0 - c0s, 0);
        check("par_err2", err2 - e2s, 1);
        check("par_hold_dx", {27'd0, if0.delta_x}, 32'h0F);
        snap();
        send_pkt(8'h08, 8'h01, 8'h01);
        expect_pkt("p5", 5'h01, 5'h1F, 5'h00, 5'h1F, 1'b0, 1'b0);

        // Stray non-header byte is dropped silently
        snap();
        send_byte(8'h00, 1'b0);
        send_pkt(8'h08, 8'h02, 8'h00);
        expect_pkt("p6", 5'h02, 5'h00, 5'h00, 5'h00, 1'b0, 1'b0);

        // Inactivity timeout after start + 4 data bits
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        wait_clks(TO + 50);
        settle();
        check("to_err0", err0 - e0s, 1);
        check("to_cur0", cur0 - c0s, 0);
        check("to_hold_dx", {27'd0, if0.delta_x}, 32'h02);

        // Reset asserted mid-frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #3 clr_n = 1'b0;
        #2;
        check("mrst_dx", {27'd0, if0.delta_x}, 32'd0);
        check("mrst_dy", {27'd0, if0.delta_y}, 32'd0);
        check("mrst_bl", {31'd0, if0.btn_left}, 32'd0);
        check("mrst_err", {31'd0, if0.pkt_err}, 32'd0);
        wait_clks(4);
        clr_n = 1'b1;
        wait_clks(HALF);
        // y sign set, byte 0: -(-256) = +256 must saturate positive; right button
        snap();
        send_pkt(8'h2A, 8'h03, 8'h00);
        expect_pkt("p7", 5'h03, 5'h0F, 5'h00, 5'h0F, 1'b0, 1'b1);

        wait_clks(5);
        settle();
        check("prev_follow", prev_bad, 0);
        check("err_cur_overlap", both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
